acc_core: RTL

Parametrised multi-cycle accumulator processor core, the next generation of the team's 8-bit accumulator processor. It generalises data width, register-file depth and program-counter width. It adds an instruction-fetch handshake that tolerates memory wait states, conditional branches on zero and carry, and a HALT state. It sits between the instruction memory (or its arbiter) and the debug/top-level logic.

---
 rtl/acc_core_pkg.sv | 41 ++++
 rtl/acc_core_alu.sv | 67 ++++++
 rtl/acc_core.sv | 128 ++++++++++++
 3 files changed

// File: rtl/acc_core_pkg.sv
// Shared types for acc_core: opcode and FSM state encodings plus flag-update helpers.
// Honours ACC_CORE_MUL_EN (opcode E becomes MUL when defined).
package acc_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDR  = 4'h2,
    OP_STR  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JC   = 4'hD,
    OP_MUL  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // One bit per opcode: set where the instruction writes acc (and so updates Z)
`ifdef ACC_CORE_MUL_EN
  localparam logic [15:0] ACC_WR_OPS = 16'b0100_0111_1111_0110;
`else
  localparam logic [15:0] ACC_WR_OPS = 16'b0000_0111_1111_0110;
`endif

  function automatic logic writes_acc(input opcode_t op);
    return ACC_WR_OPS[op];
  endfunction

endpackage

// File: rtl/acc_core_alu.sv
// Combinational ALU for acc_core; the multiplier exists only when ACC_CORE_MUL_EN is defined.
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] rdata,
  input  opcode_t           op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              carry_valid
);

`ifdef ACC_CORE_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, rdata};
`endif

  always_comb begin
    result      = acc;
    carry       = 1'b0;
    carry_valid = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, result} = {1'b0, acc} + {1'b0, rdata};
        carry_valid     = 1'b1;
      end
      OP_SUB: begin
        result      = acc - rdata;
        carry       = (acc < rdata);
        carry_valid = 1'b1;
      end
      OP_AND: begin
        result      = acc & rdata;
        carry_valid = 1'b1;
      end
      OP_OR: begin
        result      = acc | rdata;
        carry_valid = 1'b1;
      end
      OP_XOR: begin
        result      = acc ^ rdata;
        carry_valid = 1'b1;
      end
      OP_SHL: begin
        result      = {acc[DATA_W-2:0], 1'b0};
        carry       = acc[DATA_W-1];
        carry_valid = 1'b1;
      end
      OP_SHR: begin
        result      = {1'b0, acc[DATA_W-1:1]};
        carry       = acc[0];
        carry_valid = 1'b1;
      end
`ifdef ACC_CORE_MUL_EN
      OP_MUL: begin
        result      = prod[DATA_W-1:0];
        carry       = |prod[2*DATA_W-1:DATA_W];
        carry_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/HALT FSM, register file, IR and PC.
// Opcode E is MUL when ACC_CORE_MUL_EN is defined, otherwise NOP.
module acc_core
  import acc_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_N  = 4,
  parameter int PC_W   = 8,
  parameter int OPD_W  = 8
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic [OPD_W+3:0]  inst_in,
  input  logic              inst_valid,
  output logic              inst_req,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              z_flag,
  output logic              c_flag,
  output logic              halted
);

  localparam int AW    = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam int IMM_W = (DATA_W > OPD_W) ? DATA_W : OPD_W;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [OPD_W+3:0]    ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d, c_q, c_d;
  logic                inst_req_q, inst_req_d;
  logic                halted_q, halted_d;
  logic [DATA_W-1:0]   regs_q [REG_N];
  logic                rf_we;

  opcode_t             op;
  logic [OPD_W-1:0]    opd;
  logic [AW-1:0]       ra;
  logic [DATA_W-1:0]   rdata;
  logic [IMM_W-1:0]    imm_ext;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry, alu_cv;

  assign op      = opcode_t'(ir_q[OPD_W+3:OPD_W]);
  assign opd     = ir_q[OPD_W-1:0];
  assign ra      = opd[AW-1:0];
  assign rdata   = regs_q[ra];
  assign imm_ext = IMM_W'(opd);

  acc_core_alu #(.DATA_W(DATA_W)) u_alu (
    .acc         (acc_q),
    .rdata       (rdata),
    .op          (op),
    .result      (alu_result),
    .carry       (alu_carry),
    .carry_valid (alu_cv)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    rf_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (inst_valid) begin
          ir_d    = inst_in;
          pc_d    = pc_q + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        // pc already holds the fall-through address, so a taken jump just overwrites it
        case (op)
          OP_LDI:  acc_d = imm_ext[DATA_W-1:0];
          OP_LDR:  acc_d = rdata;
          OP_STR:  rf_we = 1'b1;
          OP_JMP:  pc_d  = opd[PC_W-1:0];
          OP_JZ:   if (z_q) pc_d = opd[PC_W-1:0];
          OP_JC:   if (c_q) pc_d = opd[PC_W-1:0];
          OP_HALT: state_d = ST_HALT;
          default: if (writes_acc(op)) acc_d = alu_result;
        endcase
        if (writes_acc(op)) z_d = (acc_d == '0);
        if (alu_cv)         c_d = alu_carry;
      end
      default: state_d = ST_HALT;
    endcase
    inst_req_d = (state_d == ST_FETCH);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      state_q    <= ST_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      inst_req_q <= 1'b1;
      halted_q   <= 1'b0;
      for (int unsigned i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      z_q        <= z_d;
      c_q        <= c_d;
      inst_req_q <= inst_req_d;
      halted_q   <= halted_d;
      if (rf_we) regs_q[ra] <= acc_q;
    end
  end

  assign inst_req = inst_req_q;
  assign halted   = halted_q;
  assign pc_out   = pc_q;
  assign acc_out  = acc_q;
  assign z_flag   = z_q;
  assign c_flag   = c_q;

endmodule
